// File: rtl/audio_gain_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : audio_gain_stage                                           |
// | Description : Per-sample ramped gain with soft mute and saturation to    |
// |               the codec word length, placed between I2S RX and I2S TX.   |
// |               Two-stage pipeline, one sample per clock, latency 2.       |
// | Ports       : clk, rst_n     - system clock, async active-low reset      |
// |               in_data_i      - received sample, bits [WL-1:0] used       |
// |               in_valid_i     - one-cycle strobe qualifying in_data_i     |
// |               gain_target_i  - unsigned Q1.7 gain (128 = unity)          |
// |               mute_i         - level, forces the effective target to 0   |
// |               out_data_o     - processed sample, sign-extended to 32 bit |
// |               out_valid_o    - one-cycle strobe marking new out_data_o   |
// |               clip_o         - result of this sample was saturated       |
// |               cur_gain_o     - gain currently applied                    |
// |               ramp_busy_o    - cur_gain_o differs from effective target  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module audio_gain_stage #(
   parameter int WL        = 24,
   parameter int RAMP_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   input  logic [7:0]  gain_target_i,
   input  logic        mute_i,
   output logic [31:0] out_data_o,
   output logic        out_valid_o,
   output logic        clip_o,
   output logic [7:0]  cur_gain_o,
   output logic        ramp_busy_o
);

   typedef enum logic [1:0] {
      STEADY = 2'd0,
      UP     = 2'd1,
      DOWN   = 2'd2
   } ramp_state_e;

   localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

   // Bits above the word length carry no audio.
   logic unused_hi;
   assign unused_hi = ^in_data_i[31:WL];

   // ------------------------------------------------------------------
   // Ramp control
   // ------------------------------------------------------------------
   logic [7:0]  tgt;
   logic [7:0]  cur_gain_q, cur_gain_d;
   ramp_state_e state_q, state_d;
   logic [8:0]  up_sum;
   logic [8:0]  down_lim;

   assign tgt         = mute_i ? 8'd0 : gain_target_i;
   assign ramp_busy_o = (cur_gain_q != tgt);
   assign cur_gain_o  = cur_gain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= STEADY;
         cur_gain_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cur_gain_q <= cur_gain_d;
      end
   end

   // Direction is re-decided from scratch on every accepted sample, so a
   // target change mid-ramp simply flips or stops the ramp. Comparisons are
   // done 9 bits wide so the step never wraps and the gain cannot overshoot.
   always_comb begin
      state_d    = state_q;
      cur_gain_d = cur_gain_q;
      up_sum     = {1'b0, cur_gain_q} + STEP9;
      down_lim   = {1'b0, tgt} + STEP9;
      if (in_valid_i) begin
         if (cur_gain_q < tgt) begin
            state_d    = UP;
            cur_gain_d = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[7:0];
         end else if (cur_gain_q > tgt) begin
            state_d    = DOWN;
            cur_gain_d = ({1'b0, cur_gain_q} <= down_lim) ? tgt
                                                         : (cur_gain_q - STEP9[7:0]);
         end else begin
            state_d    = STEADY;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: capture sample and the gain in force before the ramp update
   // ------------------------------------------------------------------
   logic [WL-1:0] s1_data_q;
   logic [7:0]    s1_gain_q;
   logic          s1_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data_q  <= '0;
         s1_gain_q  <= 8'd0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= in_valid_i;
         if (in_valid_i) begin
            s1_data_q <= in_data_i[WL-1:0];
            s1_gain_q <= cur_gain_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: multiply, floor-shift by 7, saturate to WL bits
   // ------------------------------------------------------------------
   logic [WL+8:0]        prod;
   logic signed [WL+8:0] shifted;
   logic [WL+8:WL-1]     top;
   logic                 fits;
   logic [WL-1:0]        sat_val;
   logic [31:0]          out_data_d;

   always_comb begin
      // Two's-complement product: the low WL+9 bits of an unsigned multiply
      // of the sign-extended sample and zero-extended gain are exact.
      prod    = {{9{s1_data_q[WL-1]}}, s1_data_q} * {{(WL+1){1'b0}}, s1_gain_q};
      shifted = $signed(prod) >>> 7;
      top     = shifted[WL+8:WL-1];
      // The result fits in WL bits when every bit from the WL-1 sign position
      // upward agrees.
      fits    = (&top) | ~(|top);
      if (fits) begin
         sat_val = shifted[WL-1:0];
      end else if (shifted[WL+8]) begin
         sat_val = {1'b1, {(WL-1){1'b0}}};
      end else begin
         sat_val = {1'b0, {(WL-1){1'b1}}};
      end
      out_data_d = {{(32-WL){sat_val[WL-1]}}, sat_val};
   end

   logic [31:0] out_data_q;
   logic        out_valid_q;
   logic        clip_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= 32'd0;
         out_valid_q <= 1'b0;
         clip_q      <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q <= out_data_d;
            clip_q     <= ~fits;
         end
      end
   end

   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign clip_o      = clip_q;

endmodule
`default_nettype wire
